// File: rtl/alu_operand_if.sv
// Operand-stage bus: register write port, operand-fetch request and operand pair output.
// Handshake: a request transfers on a rising edge where rd_valid && rd_ready; a pair transfers on a rising edge where out_valid && out_ready.
interface alu_operand_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;

  modport master (
    output wr_en, wr_addr, wr_data, rd_valid, rs_addr, rt_addr, out_ready,
    input  rd_ready, out_valid, A, B
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_valid, rs_addr, rt_addr, out_ready,
    output rd_ready, out_valid, A, B
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Register-file read stage: 2^ADDR_W x DATA_W regfile, registered operand pair A/B with valid/ready.
// Optional macro ALU_OPERAND_FORWARD_EN: same-edge write data bypasses into a matching operand read.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_operand_if.slave     bus,
  output logic             dbg_state
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              rd_ready_c;
  logic              accept;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              wr_hit;

  // Register file; entry 0 is never written so it always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign wr_hit = bus.wr_en && (bus.wr_addr != '0);

`ifdef ALU_OPERAND_FORWARD_EN
  always_comb begin
    rs_val = regs[bus.rs_addr];
    if (bus.rs_addr == '0) begin
      rs_val = '0;
    end else if (wr_hit && (bus.wr_addr == bus.rs_addr)) begin
      rs_val = bus.wr_data;
    end
  end

  always_comb begin
    rt_val = regs[bus.rt_addr];
    if (bus.rt_addr == '0) begin
      rt_val = '0;
    end else if (wr_hit && (bus.wr_addr == bus.rt_addr)) begin
      rt_val = bus.wr_data;
    end
  end
`else
  // Without the bypass a same-edge write is seen only by later requests.
  always_comb begin
    rs_val = regs[bus.rs_addr];
    if (bus.rs_addr == '0) begin
      rs_val = '0;
    end
  end

  always_comb begin
    rt_val = regs[bus.rt_addr];
    if (bus.rt_addr == '0) begin
      rt_val = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Single-entry output register: ready whenever the slot is empty or being drained.
  always_comb begin
    rd_ready_c = 1'b0;
    accept     = 1'b0;
    state_next = state;
    case (state)
      ST_EMPTY: begin
        rd_ready_c = 1'b1;
        accept     = bus.rd_valid;
        if (bus.rd_valid) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        rd_ready_c = bus.out_ready;
        accept     = bus.rd_valid && bus.out_ready;
        if (bus.out_ready && !bus.rd_valid) begin
          state_next = ST_EMPTY;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // Operands load only on accept, so a stalled pair ignores later writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= rs_val;
      b_q <= rt_val;
    end
  end

  assign bus.rd_ready  = rd_ready_c;
  assign bus.out_valid = (state == ST_FULL);
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, async-reset sequence, random run against a queue model.
module tb_alu_operand_stage;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef ALU_OPERAND_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic dbg_state;

  alu_operand_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  alu_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus a queue of outstanding pairs.
  logic [DATA_W-1:0]   mregs [1 << ADDR_W];
  logic [2*DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0]   held_a;
  logic [DATA_W-1:0]   held_b;
  logic                pre_rdy;

  typedef struct {
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              out_ready;
    logic              exp_rdy;
    logic              exp_ov;
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << ADDR_W); i++) mregs[i] = '0;
    exp_q.delete();
    held_a = '0;
    held_b = '0;
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (FWD && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return mregs[a];
  endfunction

  // Driver tasks
  task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic rv, input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                       input logic ordy);
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_valid  = rv;
    bus.rs_addr   = rs;
    bus.rt_addr   = rt;
    bus.out_ready = ordy;
  endtask

  // One clock: check ready before the edge, advance the model at the edge, check outputs after.
  task automatic step();
    logic acc;
    logic [2*DATA_W-1:0] pair;
    #1;
    pre_rdy = bus.rd_ready;
    check("rd_ready", {31'd0, bus.rd_ready}, {31'd0, (exp_q.size() == 0) || bus.out_ready});
    acc = bus.rd_valid && ((exp_q.size() == 0) || bus.out_ready);
    pair = {model_read(bus.rs_addr), model_read(bus.rt_addr)};
    @(posedge clk);
    if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(pair);
      held_a = pair[2*DATA_W-1:DATA_W];
      held_b = pair[DATA_W-1:0];
    end
    if (bus.wr_en && bus.wr_addr != 0) mregs[bus.wr_addr] = bus.wr_data;
    #1;
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
    check("A", bus.A, held_a);
    check("B", bus.B, held_b);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_A", bus.A, 32'd0);
    check("reset_B", bus.B, 32'd0);
    check("reset_rd_ready", {31'd0, bus.rd_ready}, 32'd1);

    tbl[0]  = '{1, 1, 32'd1000000007, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 2, 32'd143,        0, 0, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,              1, 1, 2, 1, 1, 1, 32'd1000000007, 32'd143};
    tbl[3]  = '{1, 0, 32'hFFFFFFFF,   1, 0, 0, 1, 1, 1, 0, 0};
    tbl[4]  = '{1, 1, 32'd1000245,    0, 0, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 2, 32'd134422,     0, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0,              1, 1, 2, 0, 1, 1, 32'd1000245, 32'd134422};
    tbl[7]  = '{1, 1, 32'd5,          1, 3, 3, 0, 0, 1, 32'd1000245, 32'd134422};
    tbl[8]  = '{0, 0, 0,              0, 0, 0, 1, 1, 0, 32'd1000245, 32'd134422};
    tbl[9]  = '{1, 3, 32'd7,          1, 1, 2, 1, 1, 1, 32'd5, 32'd134422};
    tbl[10] = '{0, 0, 0,              1, 2, 1, 1, 1, 1, 32'd134422, 32'd5};
    tbl[11] = '{0, 0, 0,              1, 3, 0, 1, 1, 1, 32'd7, 32'd0};
    tbl[12] = '{0, 0, 0,              1, 1, 3, 1, 1, 1, 32'd5, 32'd7};
    tbl[13] = '{1, 3, 32'd324521,     1, 3, 3, 1, 1, 1, FWD ? 32'd324521 : 32'd7, FWD ? 32'd324521 : 32'd7};
    tbl[14] = '{0, 0, 0,              1, 3, 3, 1, 1, 1, 32'd324521, 32'd324521};
    tbl[15] = '{0, 0, 0,              0, 0, 0, 1, 1, 0, 32'd324521, 32'd324521};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data, tbl[i].rd_valid,
            tbl[i].rs, tbl[i].rt, tbl[i].out_ready);
      step();
      check($sformatf("vec%0d_rdy", i), {31'd0, pre_rdy}, {31'd0, tbl[i].exp_rdy});
      check($sformatf("vec%0d_ov", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].exp_ov});
      check($sformatf("vec%0d_A", i), bus.A, tbl[i].exp_a);
      check($sformatf("vec%0d_B", i), bus.B, tbl[i].exp_b);
    end

    // Asynchronous reset while a pair is stalled
    drive(0, 0, 0, 1, 1, 2, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("stall_ov", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ov", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_A", bus.A, 32'd0);
    check("async_rst_B", bus.B, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 1, 1, 2, 1);
    step();
    check("post_rst_ov", {31'd0, bus.out_valid}, 32'd1);
    check("post_rst_A", bus.A, 32'd0);
    check("post_rst_B", bus.B, 32'd0);

    // Randomised traffic on a few registers so collisions are frequent
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 7, ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 6);
      step();
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
